synth_param_bank: RTL
=====================

// Module: synth_param_bank
// PURPOSE
//  Holds the user-adjustable synth settings (octave, amplitude, attack, decay, sustain, release).
//  Steps each setting from the PS2 decoder's inc/dec strobes and drives the ALU controller, HEX and VGA stages.
//  Adds press-and-hold auto-repeat, saturating arithmetic and a change strobe for display redraw.
// PARAMETERS
//  STEP          31'd16777216  ADSR/amplitude increment per step (1<<24, 64 steps full scale)
//  PARAM_MAX     31'd1073741824 upper clamp and default for amplitude/attack/sustain/release
//  OCT_DEFAULT   3'd4          octave after reset (note 0 = middle C)
//  REPEAT_DELAY  25_000_000    hold cycles before first auto-repeat (0.5 s @ 50 MHz)
//  REPEAT_PERIOD 5_000_000     cycles between auto-repeats (0.1 s)
// PORTS
//  clk                 in   1   system clock (CLOCK_50)
//  reset               in   1   asynchronous, active-high reset
//  octave_plus_plus    in   1   level: octave up held
//  octave_minus_minus  in   1   level: octave down held
//  ADSR_selector       in   3   0 amp, 1 attack, 2 decay, 3 sustain, 4 release, 5-7 none
//  ADSR_plus_plus      in   1   level: selected param up held
//  ADSR_minus_minus    in   1   level: selected param down held
//  octave              out  3   current octave
//  amplitude/attack/decay/sustain/rel  out 31 each  current settings
//  changed             out  1   one-cycle strobe when any output value actually changes
// BEHAVIOUR
//  - Reset (async): octave=OCT_DEFAULT; amplitude/attack/sustain/rel=PARAM_MAX; decay=0;
//    changed=0; both repeat FSMs IDLE, counters 0, previous-input regs 0.
//  - Inputs are registered once. Each direction pair (octave, ADSR) has its own repeat FSM.
//  - FSM states:
//    IDLE: exactly one of inc/dec high -> emit step pulse, load counter=REPEAT_DELAY-1, go DELAY.
//    DELAY: counter down; at 0 -> pulse, counter=REPEAT_PERIOD-1, go REPEAT.
//    REPEAT: counter down; at 0 -> pulse, reload.
//    DELAY/REPEAT: active input released, or both inc and dec high -> IDLE, no pulse.
//    Direction swap (inc->dec with no gap) -> treat as a new press: immediate pulse, new DELAY.
//  - Latency: input high before edge N -> step pulse in cycle N+1 -> output updated at edge N+2.
//    changed is high in the same cycle the new value first appears.
//  - Octave: saturates at 0..7. Step at the limit gives no change and changed=0.
//  - ADSR: the step applies to the param chosen by ADSR_selector, sampled in the pulse cycle.
//    Selector 5-7: step ignored.
//    Selector change mid-hold does not restart the FSM; later pulses go to the new target.
//    Up: v > PARAM_MAX-STEP ? PARAM_MAX : v+STEP. Down: v < STEP ? 0 : v-STEP. Never wrap.
//  - Octave and ADSR pulses in the same cycle both apply; changed is the OR of the two.
//  - Input held while reset deasserts: first step occurs on the third edge after deassertion.
//  - Mid-hold reset: all values return to defaults immediately. Auto-repeat resumes only via a
//    new IDLE detect, which the held input produces right away.
// STRUCTURE
//  - Shared package synth_pkg: SEL_AMP..SEL_REL codes, PARAM_MAX, OCT_DEFAULT, OCT_MAX=7.
//  - Sub-module key_autorepeat (inc, dec -> up_pulse, down_pulse, params DELAY/PERIOD).
//    Instantiated twice: one for octave, one for ADSR.
//  - Top: selector decode plus 6 saturating registers.
// TESTING (bench params: STEP=2^28, REPEAT_DELAY=8, REPEAT_PERIOD=4)
//  1. Reset high then low -> octave=4, amp/att/sus/rel=2^30, decay=0, changed=0.
//  2. octave_plus_plus high 3 cycles -> octave 4->5 at edge 2, single changed pulse, no repeat.
//  3. ADSR_sel=2, ADSR_plus_plus held 20 cycles -> decay steps at cycles 2, 10, 14, 18;
//     decay = 4*2^28 = 2^30. A further step clamps at 2^30 with changed=0.
//  4. amplitude=2^30, sel=0, ADSR_minus_minus tapped 5 times -> 0x30000000, 0x20000000,
//     0x10000000, 0, 0. The last tap gives changed=0.
//  5. octave=7 with plus pulsed -> stays 7. Both plus and minus held -> no change, FSM IDLE.
//  6. Selector 1->3 mid-repeat -> later steps hit sustain. Sel=6 -> no change.
//     Async reset mid-DELAY -> defaults in the same cycle.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants, repeat-FSM state type and saturating step helper for the synth settings bank.
package synth_pkg;

  localparam int unsigned PARAM_W  = 31;
  localparam int unsigned OCT_W    = 3;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned NUM_ADSR = 5;

  localparam logic [SEL_W-1:0] SEL_AMP = 3'd0;
  localparam logic [SEL_W-1:0] SEL_ATT = 3'd1;
  localparam logic [SEL_W-1:0] SEL_DEC = 3'd2;
  localparam logic [SEL_W-1:0] SEL_SUS = 3'd3;
  localparam logic [SEL_W-1:0] SEL_REL = 3'd4;

  localparam logic [PARAM_W-1:0] PARAM_MAX   = 31'd1073741824;
  localparam logic [OCT_W-1:0]   OCT_DEFAULT = 3'd4;
  localparam logic [OCT_W-1:0]   OCT_MAX     = 3'd7;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // One saturating step up or down; never wraps past 0 or max.
  function automatic logic [PARAM_W-1:0] sat_step(
    input logic [PARAM_W-1:0] v,
    input logic               up,
    input logic [PARAM_W-1:0] step,
    input logic [PARAM_W-1:0] max
  );
    logic [PARAM_W-1:0] r;
    if (up) begin
      r = (v > (max - step)) ? max : (v + step);
    end else begin
      r = (v < step) ? '0 : (v - step);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_autorepeat.sv
// Press-and-hold auto-repeat for one inc/dec key pair: registers the levels and emits step pulses.
module key_autorepeat
  import synth_pkg::*;
#(
  parameter int unsigned DELAY  = 25_000_000,
  parameter int unsigned PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic up_pulse,
  output logic down_pulse
);

  localparam int unsigned CNT_MAX = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(PERIOD - 1);

  rpt_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;
  logic             inc_q, dec_q;
  logic             up_nxt, down_nxt;
  logic             press;

  // Exactly one direction held counts as a press; both held cancels.
  assign press = inc_q ^ dec_q;

  // Input sampling, FSM state and registered step pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      state      <= RPT_IDLE;
      cnt        <= '0;
      dir        <= 1'b0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
    end else begin
      inc_q      <= inc;
      dec_q      <= dec;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      up_pulse   <= up_nxt;
      down_pulse <= down_nxt;
    end
  end

  // Next state: immediate pulse on press, first repeat after DELAY, then every PERIOD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    up_nxt    = 1'b0;
    down_nxt  = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (press) begin
          up_nxt    = inc_q;
          down_nxt  = dec_q;
          dir_nxt   = inc_q;
          cnt_nxt   = DELAY_LOAD;
          state_nxt = RPT_DELAY;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (!press) begin
          cnt_nxt   = '0;
          state_nxt = RPT_IDLE;
        end else if (inc_q != dir) begin
          // Direction swapped without a gap: behave like a fresh press.
          up_nxt    = inc_q;
          down_nxt  = dec_q;
          dir_nxt   = inc_q;
          cnt_nxt   = DELAY_LOAD;
          state_nxt = RPT_DELAY;
        end else if (cnt == '0) begin
          up_nxt    = dir;
          down_nxt  = ~dir;
          cnt_nxt   = PERIOD_LOAD;
          state_nxt = RPT_REPEAT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = RPT_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/synth_param_bank.sv
// User-adjustable synth settings: octave and five ADSR/amplitude values with auto-repeat stepping.
module synth_param_bank #(
  parameter logic [synth_pkg::PARAM_W-1:0] STEP          = 31'd16777216,
  parameter logic [synth_pkg::PARAM_W-1:0] PARAM_MAX     = synth_pkg::PARAM_MAX,
  parameter logic [synth_pkg::OCT_W-1:0]   OCT_DEFAULT   = synth_pkg::OCT_DEFAULT,
  parameter int unsigned                   REPEAT_DELAY  = 25_000_000,
  parameter int unsigned                   REPEAT_PERIOD = 5_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            octave_plus_plus,
  input  logic                            octave_minus_minus,
  input  logic [synth_pkg::SEL_W-1:0]     ADSR_selector,
  input  logic                            ADSR_plus_plus,
  input  logic                            ADSR_minus_minus,
  output logic [synth_pkg::OCT_W-1:0]     octave,
  output logic [synth_pkg::PARAM_W-1:0]   amplitude,
  output logic [synth_pkg::PARAM_W-1:0]   attack,
  output logic [synth_pkg::PARAM_W-1:0]   decay,
  output logic [synth_pkg::PARAM_W-1:0]   sustain,
  output logic [synth_pkg::PARAM_W-1:0]   rel,
  output logic                            changed
);

  localparam int unsigned PW = synth_pkg::PARAM_W;
  localparam int unsigned OW = synth_pkg::OCT_W;
  localparam int unsigned SW = synth_pkg::SEL_W;

  logic          oct_up, oct_down, adsr_up, adsr_down;
  logic [SW-1:0] sel_q;
  logic [OW-1:0] oct_nxt;
  logic [PW-1:0] amp_nxt, att_nxt, dcy_nxt, sus_nxt, rel_nxt;
  logic [PW-1:0] cur, stepped;
  logic          adsr_hit, oct_chg, adsr_chg;

  key_autorepeat #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_oct_rpt (
    .clk        (clk),
    .reset      (reset),
    .inc        (octave_plus_plus),
    .dec        (octave_minus_minus),
    .up_pulse   (oct_up),
    .down_pulse (oct_down)
  );

  key_autorepeat #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_adsr_rpt (
    .clk        (clk),
    .reset      (reset),
    .inc        (ADSR_plus_plus),
    .dec        (ADSR_minus_minus),
    .up_pulse   (adsr_up),
    .down_pulse (adsr_down)
  );

  // Current value of the parameter addressed by the registered selector.
  always_comb begin
    cur = '0;
    case (sel_q)
      synth_pkg::SEL_AMP: cur = amplitude;
      synth_pkg::SEL_ATT: cur = attack;
      synth_pkg::SEL_DEC: cur = decay;
      synth_pkg::SEL_SUS: cur = sustain;
      synth_pkg::SEL_REL: cur = rel;
      default:            cur = '0;
    endcase
  end

  assign stepped  = synth_pkg::sat_step(cur, adsr_up, STEP, PARAM_MAX);
  assign adsr_hit = (adsr_up | adsr_down) && (sel_q <= synth_pkg::SEL_REL);

  // Saturating next values; a change flag is raised only when a value really moves.
  always_comb begin
    oct_nxt  = octave;
    amp_nxt  = amplitude;
    att_nxt  = attack;
    dcy_nxt  = decay;
    sus_nxt  = sustain;
    rel_nxt  = rel;
    oct_chg  = 1'b0;
    adsr_chg = 1'b0;
    if (oct_up && (octave != synth_pkg::OCT_MAX)) begin
      oct_nxt = octave + OW'(1);
      oct_chg = 1'b1;
    end else if (oct_down && (octave != '0)) begin
      oct_nxt = octave - OW'(1);
      oct_chg = 1'b1;
    end
    if (adsr_hit && (stepped != cur)) begin
      adsr_chg = 1'b1;
      case (sel_q)
        synth_pkg::SEL_AMP: amp_nxt = stepped;
        synth_pkg::SEL_ATT: att_nxt = stepped;
        synth_pkg::SEL_DEC: dcy_nxt = stepped;
        synth_pkg::SEL_SUS: sus_nxt = stepped;
        synth_pkg::SEL_REL: rel_nxt = stepped;
        default: ;
      endcase
    end
  end

  // Setting registers, selector sample and redraw strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      octave    <= OCT_DEFAULT;
      amplitude <= PARAM_MAX;
      attack    <= PARAM_MAX;
      decay     <= '0;
      sustain   <= PARAM_MAX;
      rel       <= PARAM_MAX;
      changed   <= 1'b0;
    end else begin
      sel_q     <= ADSR_selector;
      octave    <= oct_nxt;
      amplitude <= amp_nxt;
      attack    <= att_nxt;
      decay     <= dcy_nxt;
      sustain   <= sus_nxt;
      rel       <= rel_nxt;
      changed   <= oct_chg | adsr_chg;
    end
  end

endmodule
